// File: rtl/shift_seq_if.sv
// Request/response bundle between the operand latch and the multi-cycle shifter.
// The master drives a shift request; the slave returns busy, result_valid and result.
interface shift_seq_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned OP_W   = 2;

  logic              start;
  logic [DATA_W-1:0] operand;
  logic [AMT_W-1:0]  shamt;
  logic [OP_W-1:0]   op;
  logic              busy;
  logic              result_valid;
  logic [DATA_W-1:0] result;

  modport master (
    output start, operand, shamt, op,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, operand, shamt, op,
    output busy, result_valid, result
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle 32-bit shifter: applies the 16/8/4/2/1 power-of-two stages one per clock
// to a working register, then presents a one-cycle result_valid pulse.
module shift_seq (
  input  logic        clock,
  input  logic        reset,
  shift_seq_if.slave  bus
);
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned AMT_W      = 5;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned STAGE_W    = 3;
  localparam int unsigned LAST_STAGE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [OP_W-1:0] OP_SLL = 2'b00;
  localparam logic [OP_W-1:0] OP_SRA = 2'b01;
  localparam logic [OP_W-1:0] OP_SRL = 2'b10;

  state_t              state_q, state_n;
  logic [STAGE_W-1:0]  stage_q, stage_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic [AMT_W-1:0]    amt_q, amt_n;
  logic [OP_W-1:0]     op_q, op_n;
  logic [DATA_W-1:0]   result_q, result_n;
  logic                busy_q, busy_n;
  logic                valid_q, valid_n;
  logic [DATA_W-1:0]   stage_val;

  // One fixed-distance stage; d = 16 >> stage, so the rotate complement is 32 - d.
  function automatic logic [DATA_W-1:0] stage_shift(
    input logic [DATA_W-1:0]  val,
    input logic [STAGE_W-1:0] stage,
    input logic [OP_W-1:0]    op
  );
    logic [AMT_W-1:0]  d;
    logic [AMT_W:0]    rd;
    logic [DATA_W-1:0] r;
    d  = AMT_W'(5'd16 >> stage);
    rd = (AMT_W+1)'(6'd32 - {1'b0, d});
    case (op)
      OP_SLL:  r = val << d;
      OP_SRL:  r = val >> d;
      OP_SRA:  r = DATA_W'($signed(val) >>> d);
      default: r = (val >> d) | (val << rd);
    endcase
    return r;
  endfunction

  // Stage amount bits are consumed MSB first: stage 0 tests amt_q[4] (distance 16).
  always_comb begin
    stage_val = data_q;
    if (amt_q[STAGE_W'(LAST_STAGE) - stage_q]) begin
      stage_val = stage_shift(data_q, stage_q, op_q);
    end
  end

  // State and working registers; asynchronous reset discards any in-flight shift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      data_q   <= '0;
      amt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      stage_q  <= stage_n;
      data_q   <= data_n;
      amt_q    <= amt_n;
      op_q     <= op_n;
      result_q <= result_n;
      busy_q   <= busy_n;
      valid_q  <= valid_n;
    end
  end

  // Next-state and datapath; busy/valid are registered copies of the next-state decode.
  always_comb begin
    state_n  = state_q;
    stage_n  = stage_q;
    data_n   = data_q;
    amt_n    = amt_q;
    op_n     = op_q;
    result_n = result_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          data_n  = bus.operand;
          amt_n   = bus.shamt;
          op_n    = bus.op;
          stage_n = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        data_n = stage_val;
        if (stage_q == STAGE_W'(LAST_STAGE)) begin
          result_n = stage_val;
          stage_n  = '0;
          state_n  = DONE;
        end else begin
          stage_n = stage_q + STAGE_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n  = (state_n != IDLE);
    valid_n = (state_n == DONE);
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
endmodule

// File: tb/tb_shift_seq.sv
// Directed and random checks of shift_seq: latency, handshake, busy rejection,
// input churn, asynchronous mid-operation reset and a reference-model sweep.
module tb_shift_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  shift_seq_if sif ();

  shift_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s,
                                        input logic [1:0] o);
    logic [31:0] m;
    case (o)
      2'b00:   m = a << s;
      2'b01:   m = $signed(a) >>> s;
      2'b10:   m = a >> s;
      default: m = (s == 5'd0) ? a : ((a >> s) | (a << (6'd32 - {1'b0, s})));
    endcase
    return m;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request from IDLE; lat = edges from accept to the first result_valid (-1 on timeout).
  task automatic do_shift(input logic [31:0] a, input logic [4:0] s, input logic [1:0] o,
                          input bit churn, output int lat, output logic [31:0] res);
    sif.operand = a;
    sif.shamt   = s;
    sif.op      = o;
    sif.start   = 1'b1;
    tick();
    sif.start = 1'b0;
    lat = -1;
    res = 'x;
    for (int k = 1; k <= 20; k++) begin
      if (churn) begin
        sif.operand = $urandom;
        sif.shamt   = 5'($urandom_range(0, 31));
        sif.op      = 2'($urandom_range(0, 3));
      end
      tick();
      if (sif.result_valid === 1'b1) begin
        lat = k;
        res = sif.result;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    sif.start = 1'b0; sif.operand = '0; sif.shamt = '0; sif.op = '0;
    #2;
    n_cmp++; if (sif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", sif.busy); end
    n_cmp++; if (sif.result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", sif.result_valid); end
    n_cmp++; if (sif.result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", sif.result); end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sra_timing();
    sif.operand = 32'h8000_0000; sif.shamt = 5'd16; sif.op = 2'b01; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    n_cmp++; if (sif.busy !== 1'b1) begin n_bad++; $display("FAIL sra_busy_rise got %b want 1", sif.busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if (sif.result_valid !== (k == 5) || sif.busy !== 1'b1) begin
        n_bad++; $display("FAIL sra_edge%0d valid=%b busy=%b want valid=%b busy=1", k, sif.result_valid, sif.busy, k == 5);
      end
    end
    n_cmp++; if (sif.result !== 32'hFFFF_8000) begin n_bad++; $display("FAIL sra_result got %h want ffff8000", sif.result); end
    tick();
    n_cmp++;
    if (sif.busy !== 1'b0 || sif.result_valid !== 1'b0 || sif.result !== 32'hFFFF_8000) begin
      n_bad++; $display("FAIL sra_edge6 busy=%b valid=%b result=%h want 0 0 ffff8000", sif.busy, sif.result_valid, sif.result);
    end
  endtask

  task automatic test_extremes();
    logic [31:0] va [8] = '{32'h0000_0001, 32'hF000_0000, 32'h7FFF_FFFF, 32'h0000_0001,
                            32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    logic [4:0]  vs [8] = '{5'd31, 5'd4, 5'd31, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [1:0]  vo [8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] ve [8] = '{32'h8000_0000, 32'h0F00_0000, 32'h0000_0000, 32'h8000_0000,
                            32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 8; i++) begin
      do_shift(va[i], vs[i], vo[i], 1'b0, lat, res);
      n_cmp++;
      if (res !== ve[i] || lat != 5) begin
        n_bad++; $display("FAIL extreme%0d result=%h lat=%0d want %h lat=5", i, res, lat, ve[i]);
      end
    end
  endtask

  task automatic test_busy_reject();
    int pulses = 0;
    int lat;
    logic [31:0] res;
    logic [31:0] got = '0;
    sif.operand = 32'h0000_0010; sif.shamt = 5'd4; sif.op = 2'b00; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) begin
        sif.start = 1'b1; sif.operand = 32'hFFFF_FFFF; sif.shamt = 5'd31; sif.op = 2'b11;
      end else begin
        sif.start = 1'b0;
      end
      tick();
      if (sif.result_valid === 1'b1) begin pulses++; got = sif.result; end
    end
    sif.start = 1'b1; sif.operand = 32'hFFFF_FFFF;
    tick();
    sif.start = 1'b0;
    if (sif.result_valid === 1'b1) pulses++;
    n_cmp++; if (sif.busy !== 1'b0) begin n_bad++; $display("FAIL reject_busy_n6 got %b want 0", sif.busy); end
    tick();
    if (sif.result_valid === 1'b1) pulses++;
    n_cmp++; if (sif.busy !== 1'b0) begin n_bad++; $display("FAIL reject_done_start busy=%b want 0", sif.busy); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL reject_pulses got %0d want 1", pulses); end
    n_cmp++; if (got !== 32'h0000_0100) begin n_bad++; $display("FAIL reject_result got %h want 00000100", got); end
    do_shift(32'hFFFF_FFFF, 5'd4, 2'b10, 1'b0, lat, res);
    n_cmp++;
    if (res !== 32'h0FFF_FFFF || lat != 5) begin
      n_bad++; $display("FAIL reject_next result=%h lat=%0d want 0fffffff lat=5", res, lat);
    end
  endtask

  task automatic test_churn();
    int lat;
    logic [31:0] res;
    do_shift(32'h8000_0000, 5'd8, 2'b01, 1'b1, lat, res);
    n_cmp++;
    if (res !== 32'hFF80_0000 || lat != 5) begin
      n_bad++; $display("FAIL churn result=%h lat=%0d want ff800000 lat=5", res, lat);
    end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    sif.operand = 32'h8000_0000; sif.shamt = 5'd8; sif.op = 2'b01; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (sif.busy !== 1'b1 || sif.result !== 32'hFF80_0000) begin
      n_bad++; $display("FAIL midrst_pre busy=%b result=%h want 1 ff800000", sif.busy, sif.result);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (sif.busy !== 1'b0 || sif.result_valid !== 1'b0 || sif.result !== 32'h0) begin
      n_bad++; $display("FAIL midrst_async busy=%b valid=%b result=%h want 0 0 0", sif.busy, sif.result_valid, sif.result);
    end
    tick();
    #3 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (sif.result_valid === 1'b1 || sif.busy !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL midrst_after activity=%0d want 0", pulses); end
  endtask

  task automatic test_reset_start();
    logic [31:0] res = 'x;
    reset = 1'b1;
    sif.operand = 32'h0000_000F; sif.shamt = 5'd4; sif.op = 2'b00; sif.start = 1'b1;
    tick();
    #2 reset = 1'b0;
    tick();
    sif.start = 1'b0;
    n_cmp++; if (sif.busy !== 1'b1) begin n_bad++; $display("FAIL rststart_accept busy=%b want 1", sif.busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (sif.result_valid === 1'b1) res = sif.result;
    end
    n_cmp++; if (res !== 32'h0000_00F0) begin n_bad++; $display("FAIL rststart_result got %h want 000000f0", res); end
    tick();
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] res, a, e;
    logic [4:0] s;
    logic [1:0] o;
    for (int i = 0; i < 2000; i++) begin
      a = $urandom;
      s = 5'($urandom_range(0, 31));
      o = 2'($urandom_range(0, 3));
      e = model(a, s, o);
      do_shift(a, s, o, 1'b1, lat, res);
      n_cmp++;
      if (res !== e || lat != 5) begin
        n_bad++; $display("FAIL random%0d a=%h s=%0d op=%0d result=%h lat=%0d want %h lat=5", i, a, s, o, res, lat, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sra_timing();
    test_extremes();
    test_busy_reject();
    test_churn();
    test_mid_reset();
    test_reset_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
